ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_pkg.sv | 18 +
 rtl/ram_bist_cmp.sv | 46 ++++
 rtl/ram_bist_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST controller.
// Optional feature macro: BIST_ERR_LOG_EN (first-failure address/data log).
package ram_bist_pkg;

    localparam int unsigned ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_PAT,
        RD_PAT,
        WR_INV,
        RD_INV,
        DRAIN,
        DONE
    } bist_state_e;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-latency delay line for expected data/address/valid plus the compare.
module ram_bist_cmp #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  mismatch_c,
    output logic [ADDR_WIDTH-1:0] cmp_addr_c
);

    logic [RD_LAT-1:0]                 vld_q;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] exp_q;
    logic [RD_LAT-1:0][ADDR_WIDTH-1:0] addr_q;

    // Shift each read's expectation alongside the RAM's read latency; flush kills in-flight compares.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            exp_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= rd_vld && !flush;
            exp_q[0]  <= rd_exp;
            addr_q[0] <= rd_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1] && !flush;
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // Compare returning data against the delayed expectation.
    always_comb begin
        mismatch_c = vld_q[RD_LAT-1] && (data_out != exp_q[RD_LAT-1]);
        cmp_addr_c = addr_q[RD_LAT-1];
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: pattern / inverse-pattern march with mismatch counting.
// Optional feature macro: BIST_ERR_LOG_EN (log address and data of first mismatch).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  write_enb,
    output logic                  read_enb,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ERR_W-1:0]      err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  inv_q, inv_d;
    logic                  wr_d, rd_d, busy_d, done_d, pass_d;
    logic                  start_acc_c, active_c, cnt_en_c, flush_c;
    logic                  mismatch_c;
    logic [ADDR_WIDTH-1:0] cmp_addr_c;
    logic [DATA_WIDTH-1:0] rd_exp_c;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                  input logic [ADDR_WIDTH-1:0] a);
        return s ^ DATA_WIDTH'(a);
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            address   <= '0;
            write_enb <= 1'b0;
            read_enb  <= 1'b0;
            data_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            seed_q    <= '0;
            cnt_q     <= '0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            address   <= addr_d;
            write_enb <= wr_d;
            read_enb  <= rd_d;
            data_in   <= din_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            seed_q    <= seed_d;
            cnt_q     <= cnt_d;
            inv_q     <= inv_d;
        end
    end

    // Next state, address sequencing, error counting and next output values.
    always_comb begin
        state_d     = state_q;
        addr_d      = address;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        err_d       = err_count;
        start_acc_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    start_acc_c = 1'b1;
                    state_d     = WR_PAT;
                    addr_d      = '0;
                    seed_d      = seed;
                end
            end
            WR_PAT: begin
                if (address == ADDR_LAST) begin
                    state_d = RD_PAT;
                    addr_d  = '0;
                end else begin
                    addr_d = address + ADDR_WIDTH'(1);
                end
            end
            RD_PAT: begin
                if (address == ADDR_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                end else begin
                    addr_d = address + ADDR_WIDTH'(1);
                end
            end
            WR_INV: begin
                if (address == '0) begin
                    state_d = RD_INV;
                    addr_d  = ADDR_LAST;
                end else begin
                    addr_d = address - ADDR_WIDTH'(1);
                end
            end
            RD_INV: begin
                if (address == '0) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    inv_d   = 1'b1;
                end else begin
                    addr_d = address - ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = inv_q ? DONE : WR_INV;
                    addr_d  = ADDR_LAST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        active_c = !(state_q inside {IDLE, DONE});
        if (abort && active_c) begin
            state_d = IDLE;
            addr_d  = '0;
        end

        // Compares still in flight when abort lands are discarded.
        cnt_en_c = active_c && !abort;
        flush_c  = start_acc_c || (abort && active_c);

        if (start_acc_c) begin
            err_d = '0;
        end else if (cnt_en_c && mismatch_c && (err_count != ERR_MAX)) begin
            err_d = err_count + ERR_W'(1);
        end

        wr_d   = state_d inside {WR_PAT, WR_INV};
        rd_d   = state_d inside {RD_PAT, RD_INV};
        busy_d = !(state_d inside {IDLE, DONE});
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
        din_d  = '0;
        if (state_d == WR_PAT) begin
            din_d = pat(seed_d, addr_d);
        end else if (state_d == WR_INV) begin
            din_d = ~pat(seed_d, addr_d);
        end
    end

    // Expectation for the read currently on the bus.
    always_comb begin
        rd_exp_c = (state_q == RD_INV) ? ~pat(seed_q, address) : pat(seed_q, address);
    end

    ram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_cmp (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_c),
        .rd_vld     (read_enb),
        .rd_addr    (address),
        .rd_exp     (rd_exp_c),
        .data_out   (data_out),
        .mismatch_c (mismatch_c),
        .cmp_addr_c (cmp_addr_c)
    );

`ifdef BIST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;

    // Hold address and returned data of the first mismatch of the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (start_acc_c) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (cnt_en_c && mismatch_c && (err_count == '0)) begin
            fail_addr_q <= cmp_addr_c;
            fail_data_q <= data_out;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    logic [ADDR_WIDTH-1:0] unused_cmp_addr;
    assign unused_cmp_addr = cmp_addr_c;
    assign fail_addr       = '0;
    assign fail_data       = '0;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: default, RD_LAT=3 and ADDR_WIDTH=8 instances.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] seed;

    // Instance A: default parameters
    logic       start_a, abort_a, wr_a, rd_a, busy_a, done_a, pass_a;
    logic [3:0] addr_a, faddr_a;
    logic [7:0] din_a, dout_a, err_a, fdata_a;
    // Instance B: RD_LAT = 3
    logic       start_b, abort_b, wr_b, rd_b, busy_b, done_b, pass_b;
    logic [3:0] addr_b, faddr_b;
    logic [7:0] din_b, dout_b, err_b, fdata_b;
    // Instance C: ADDR_WIDTH = 8, RAM always returns zero
    logic       start_c, abort_c, wr_c, rd_c, busy_c, done_c, pass_c;
    logic [7:0] addr_c, faddr_c;
    logic [7:0] din_c, dout_c, err_c, fdata_c;
    assign dout_c = 8'h00;

    ram_bist_ctrl u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .seed(seed),
        .write_enb(wr_a), .read_enb(rd_a), .address(addr_a), .data_in(din_a),
        .data_out(dout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_addr(faddr_a), .fail_data(fdata_a)
    );

    ram_bist_ctrl #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .seed(seed),
        .write_enb(wr_b), .read_enb(rd_b), .address(addr_b), .data_in(din_b),
        .data_out(dout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_addr(faddr_b), .fail_data(fdata_b)
    );

    ram_bist_ctrl #(.ADDR_WIDTH(8)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .seed(seed),
        .write_enb(wr_c), .read_enb(rd_c), .address(addr_c), .data_in(din_c),
        .data_out(dout_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_addr(faddr_c), .fail_data(fdata_c)
    );

`ifdef BIST_ERR_LOG_EN
    localparam logic [3:0] EXP_FADDR = 4'd3;
    localparam logic [7:0] EXP_FDATA = 8'hA7;
`else
    localparam logic [3:0] EXP_FADDR = 4'd0;
    localparam logic [7:0] EXP_FDATA = 8'h00;
`endif

    // RAM A: one-cycle read, optional bit0 stuck-at-1 on address 3, optional all-zero reads
    logic [7:0] mem_a [16];
    bit stuck_a = 1'b0;
    bit zero_a  = 1'b0;
    always @(posedge clk) begin
        if (wr_a) mem_a[addr_a] <= din_a;
        if (rd_a) dout_a <= zero_a ? 8'h00 :
                            (mem_a[addr_a] | ((stuck_a && addr_a == 4'd3) ? 8'h01 : 8'h00));
    end

    // RAM B: three-cycle read pipeline
    logic [7:0] mem_b [16];
    logic [7:0] rb0, rb1;
    always @(posedge clk) begin
        if (wr_b) mem_b[addr_b] <= din_b;
        rb0    <= mem_b[addr_b];
        rb1    <= rb0;
        dout_b <= rb1;
    end

    // Monitors: strobe conflicts, address order of one A run, drain gaps of one B run
    int both_cnt  = 0;
    int cur_drain = 0;
    int q_addr[$];
    int drain_runs[$];
    bit log_a = 1'b0;
    bit log_b = 1'b0;
    always @(negedge clk) begin
        if ((wr_a && rd_a) || (wr_b && rd_b) || (wr_c && rd_c)) both_cnt <= both_cnt + 1;
        if (log_a && (wr_a || rd_a)) q_addr.push_back(int'(addr_a));
        if (log_b) begin
            if (busy_b && !wr_b && !rd_b) cur_drain <= cur_drain + 1;
            else if (cur_drain != 0) begin
                drain_runs.push_back(cur_drain);
                cur_drain <= 0;
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Start A, optionally re-pulse start (and change seed) at a given busy cycle; count busy cycles to done.
    task automatic run_a(input int poke_at, output int cyc);
        int it;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("a_err_clr", 32'(err_a), 32'd0);
        check("a_flog_clr", 32'(faddr_a), 32'd0);
        check("a_pass_busy", 32'(pass_a), 32'd0);
        cyc = 0;
        it  = 0;
        while (done_a !== 1'b1 && it < 3000) begin
            if (busy_a === 1'b1) cyc++;
            if (cyc == poke_at) begin
                start_a = 1'b1;
                seed    = 8'h3C;
            end
            @(negedge clk);
            start_a = 1'b0;
            it++;
        end
    endtask

    initial begin
        int cyc, it, bad, acc;
        int exp_seq[64];
        reset   = 1'b1;
        seed    = 8'hA5;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        start_c = 1'b0; abort_c = 1'b0;
        #1;
        check("rst_wr", 32'(wr_a), 32'd0);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_din", 32'(din_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_faddr", 32'(faddr_a), 32'd0);
        check("rst_fdata", 32'(fdata_a), 32'd0);
        #21 reset = 1'b0;

        // Fault-free run, seed A5
        log_a = 1'b1;
        run_a(-1, cyc);
        log_a = 1'b0;
        check("r1_cycles", 32'(cyc), 32'd66);
        check("r1_done", 32'(done_a), 32'd1);
        check("r1_pass", 32'(pass_a), 32'd1);
        check("r1_err", 32'(err_a), 32'd0);
        check("r1_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_seq[i]      = i;
            exp_seq[16 + i] = i;
            exp_seq[32 + i] = 15 - i;
            exp_seq[48 + i] = 15 - i;
        end
        bad = (q_addr.size() != 64) ? 1 : 0;
        if (bad == 0) begin
            for (int i = 0; i < 64; i++) if (q_addr[i] != exp_seq[i]) bad++;
        end
        check("r1_addr_seq", 32'(bad), 32'd0);
        check("r1_mem0", 32'(mem_a[0]), 32'h5A);
        check("r1_mem15", 32'(mem_a[15]), 32'h55);

        // Bit0 stuck-at-1 on address 3: only the RD_PAT read of A6 returns A7
        stuck_a = 1'b1;
        run_a(-1, cyc);
        stuck_a = 1'b0;
        check("stk_done", 32'(done_a), 32'd1);
        check("stk_pass", 32'(pass_a), 32'd0);
        check("stk_err", 32'(err_a), 32'd1);
        check("stk_faddr", 32'(faddr_a), 32'(EXP_FADDR));
        check("stk_fdata", 32'(fdata_a), 32'(EXP_FDATA));

        // All-zero RAM: every one of the 32 reads misses
        zero_a = 1'b1;
        run_a(-1, cyc);
        zero_a = 1'b0;
        check("zero_cycles", 32'(cyc), 32'd66);
        check("zero_err", 32'(err_a), 32'd32);
        check("zero_pass", 32'(pass_a), 32'd0);

        // Abort during RD_PAT at address 7
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        it = 0;
        while (!(rd_a === 1'b1 && addr_a === 4'd7) && it < 200) begin
            @(negedge clk);
            it++;
        end
        check("abt_found", 32'(rd_a), 32'd1);
        abort_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        start_a = 1'b0;
        check("abt_rd", 32'(rd_a), 32'd0);
        check("abt_wr", 32'(wr_a), 32'd0);
        check("abt_busy", 32'(busy_a), 32'd0);
        check("abt_done", 32'(done_a), 32'd0);
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            acc += int'(wr_a | rd_a | busy_a | done_a);
        end
        check("abt_idle", 32'(acc), 32'd0);
        run_a(-1, cyc);
        check("abt_rerun_cycles", 32'(cyc), 32'd66);
        check("abt_rerun_pass", 32'(pass_a), 32'd1);

        // Start re-pulsed in WR_INV (busy cycle 40) with a new seed on the bus: ignored
        run_a(40, cyc);
        check("ign_cycles", 32'(cyc), 32'd66);
        check("ign_pass", 32'(pass_a), 32'd1);
        check("ign_err", 32'(err_a), 32'd0);
        repeat (3) @(negedge clk);
        check("ign_done_hold", 32'(done_a), 32'd1);
        check("ign_pass_hold", 32'(pass_a), 32'd1);

        // Reset mid-run
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mrst_wr", 32'(wr_a), 32'd0);
        check("mrst_busy", 32'(busy_a), 32'd0);
        check("mrst_addr", 32'(addr_a), 32'd0);
        #1 reset = 1'b0;
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            acc += int'(wr_a | rd_a | busy_a);
        end
        check("mrst_quiet", 32'(acc), 32'd0);

        // RD_LAT = 3 instance
        seed  = 8'hA5;
        log_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        cyc = 0;
        it  = 0;
        while (done_b !== 1'b1 && it < 3000) begin
            if (busy_b === 1'b1) cyc++;
            @(negedge clk);
            it++;
        end
        @(negedge clk);
        log_b = 1'b0;
        check("b_cycles", 32'(cyc), 32'd70);
        check("b_pass", 32'(pass_b), 32'd1);
        check("b_err", 32'(err_b), 32'd0);
        check("b_faddr", 32'(faddr_b), 32'd0);
        check("b_fdata", 32'(fdata_b), 32'd0);
        check("b_drain_n", 32'(drain_runs.size()), 32'd2);
        if (drain_runs.size() == 2) begin
            check("b_drain0", 32'(drain_runs[0]), 32'd3);
            check("b_drain1", 32'(drain_runs[1]), 32'd3);
        end

        // ADDR_WIDTH = 8 with zero RAM: 510 misses saturate at 255
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        cyc = 0;
        it  = 0;
        while (done_c !== 1'b1 && it < 5000) begin
            if (busy_c === 1'b1) cyc++;
            @(negedge clk);
            it++;
        end
        check("c_cycles", 32'(cyc), 32'd1026);
        check("c_err_sat", 32'(err_c), 32'd255);
        check("c_pass", 32'(pass_c), 32'd0);
        check("c_addr", 32'(faddr_c), 32'd0);
        check("c_data", 32'(fdata_c), 32'd0);
        check("c_wr_din", 32'(wr_c | (|din_c)), 32'd0);

        check("no_dual_strobe", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
